// File: rtl/rega_controlador_if.sv
// Sensor, operator and actuator/flag bundle for the irrigation controller.
// The master side drives the raw sensors and operator inputs; the slave side
// (the controller) returns the level/error flags, actuators and display select.
interface rega_controlador_if;
    logic Sn_Baixo;
    logic Sn_Medio;
    logic Sn_Alto;
    logic Seco;
    logic Modo_Asp;
    logic Rearme;
    logic Nv_Critico;
    logic Nv_Baixo;
    logic Nv_Medio;
    logic Nv_Alto;
    logic ERRO;
    logic Bs;
    logic Vs;
    logic Sd;
    logic Valvula_Ent;

    modport master (
        output Sn_Baixo, Sn_Medio, Sn_Alto, Seco, Modo_Asp, Rearme,
        input  Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, ERRO, Bs, Vs, Sd, Valvula_Ent
    );

    modport slave (
        input  Sn_Baixo, Sn_Medio, Sn_Alto, Seco, Modo_Asp, Rearme,
        output Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, ERRO, Bs, Vs, Sd, Valvula_Ent
    );
endinterface

// File: rtl/rega_controlador.sv
// Irrigation control stage: debounces the tank float sensors and the soil
// moisture sensor, classifies the tank level into one-hot flags, and runs a
// Moore FSM (IDLE/REGA/ENCHE/FALHA) driving the sprinkler, drip and inlet valve.
// Also produces the periodic display view select Sd.
// Optional feature: define REGA_WATCHDOG_EN to enable the fill watchdog, which
// forces FALHA when ENCHE sees no level rise for FILL_TIMEOUT cycles.
module rega_controlador #(
    parameter int DEB_CYCLES   = 4,
    parameter int SD_PERIOD    = 25000000,
    parameter int FILL_TIMEOUT = 1000
) (
    input logic                clk,
    input logic                rst,
    rega_controlador_if.slave  bus
);

    localparam int                DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam int                SD_W     = $clog2(SD_PERIOD);
    localparam logic [SD_W-1:0]   SD_LAST  = SD_W'(SD_PERIOD - 1);

    if (DEB_CYCLES < 1 || SD_PERIOD < 2 || FILL_TIMEOUT < 1) begin : g_param_check
        $error("rega_controlador: DEB_CYCLES>=1, SD_PERIOD>=2, FILL_TIMEOUT>=1 required");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REGA  = 2'd1,
        ENCHE = 2'd2,
        FALHA = 2'd3
    } state_t;

    // Index 0 = Baixo, 1 = Medio, 2 = Alto, 3 = Seco
    logic [3:0]       raw;
    logic [3:0]       deb;
    logic [DEB_W-1:0] deb_cnt [4];

    logic cls_crit, cls_baixo, cls_medio, cls_alto, cls_inv;
    logic lvl_crit, lvl_baixo, lvl_medio, lvl_alto, lvl_inv, seco_q;

    state_t state_q, state_d;
    logic   mode_q, mode_d;
    logic   bs_q, bs_d, vs_q, vs_d, valv_q, valv_d;

    logic nv_crit_q, nv_baixo_q, nv_medio_q, nv_alto_q, erro_q, erro_d;

    logic [SD_W-1:0] sd_cnt;
    logic            sd_q;

    logic wd_expired;

    assign raw = {bus.Seco, bus.Sn_Alto, bus.Sn_Medio, bus.Sn_Baixo};

    // Debounce: a sensor only changes after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (raw[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Decode the debounced {Alto,Medio,Baixo} code; anything non-monotonic is invalid
    always_comb begin
        cls_crit  = (deb[2:0] == 3'b000);
        cls_baixo = (deb[2:0] == 3'b001);
        cls_medio = (deb[2:0] == 3'b011);
        cls_alto  = (deb[2:0] == 3'b111);
        cls_inv   = !(cls_crit || cls_baixo || cls_medio || cls_alto);
    end

    // Registered level classification and moisture, the view the FSM decides on
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_crit  <= 1'b0;
            lvl_baixo <= 1'b0;
            lvl_medio <= 1'b0;
            lvl_alto  <= 1'b0;
            lvl_inv   <= 1'b0;
            seco_q    <= 1'b0;
        end else begin
            lvl_crit  <= cls_crit;
            lvl_baixo <= cls_baixo;
            lvl_medio <= cls_medio;
            lvl_alto  <= cls_alto;
            lvl_inv   <= cls_inv;
            seco_q    <= deb[3];
        end
    end

`ifdef REGA_WATCHDOG_EN
    localparam int               WD_W    = $clog2(FILL_TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(FILL_TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            level_rise;

    assign level_rise = (lvl_crit && cls_baixo) || (lvl_baixo && cls_medio);
    assign wd_expired = (state_q == ENCHE) && (wd_cnt == WD_LAST);

    // Fill watchdog: restarts on entering ENCHE and on every level step upward
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state_q != ENCHE || level_rise) begin
            wd_cnt <= '0;
        end else if (!wd_expired) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // Next state with invalid > critical > moisture priority; actuators follow the next state
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (lvl_inv) begin
                    state_d = FALHA;
                end else if (lvl_crit) begin
                    state_d = ENCHE;
                end else if (seco_q) begin
                    state_d = REGA;
                    mode_d  = bus.Modo_Asp;
                end
            end
            REGA: begin
                if (lvl_inv)       state_d = FALHA;
                else if (lvl_crit) state_d = ENCHE;
                else if (!seco_q)  state_d = IDLE;
            end
            ENCHE: begin
                if (lvl_inv || wd_expired) state_d = FALHA;
                else if (lvl_alto)         state_d = IDLE;
            end
            FALHA: begin
                if (bus.Rearme && !lvl_inv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bs_d   = (state_d == REGA) && mode_d;
        vs_d   = (state_d == REGA) && !mode_d;
        valv_d = (state_d == ENCHE);
        erro_d = cls_inv || (state_d == FALHA);
    end

    // State, latched irrigation mode and actuators registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            bs_q    <= 1'b0;
            vs_q    <= 1'b0;
            valv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            bs_q    <= bs_d;
            vs_q    <= vs_d;
            valv_q  <= valv_d;
        end
    end

    // Output flags: level one-hot, masked by the error flag so exactly one is set
    always_ff @(posedge clk) begin
        if (rst) begin
            nv_crit_q  <= 1'b0;
            nv_baixo_q <= 1'b0;
            nv_medio_q <= 1'b0;
            nv_alto_q  <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            nv_crit_q  <= cls_crit  && (state_d != FALHA);
            nv_baixo_q <= cls_baixo && (state_d != FALHA);
            nv_medio_q <= cls_medio && (state_d != FALHA);
            nv_alto_q  <= cls_alto  && (state_d != FALHA);
            erro_q     <= erro_d;
        end
    end

    // Display view select toggles every SD_PERIOD cycles, pinned to level view on error
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_cnt <= '0;
            sd_q   <= 1'b0;
        end else if (erro_d) begin
            sd_cnt <= '0;
            sd_q   <= 1'b0;
        end else if (sd_cnt == SD_LAST) begin
            sd_cnt <= '0;
            sd_q   <= !sd_q;
        end else begin
            sd_cnt <= sd_cnt + SD_W'(1);
        end
    end

    assign bus.Nv_Critico  = nv_crit_q;
    assign bus.Nv_Baixo    = nv_baixo_q;
    assign bus.Nv_Medio    = nv_medio_q;
    assign bus.Nv_Alto     = nv_alto_q;
    assign bus.ERRO        = erro_q;
    assign bus.Bs          = bs_q;
    assign bus.Vs          = vs_q;
    assign bus.Valvula_Ent = valv_q;
    assign bus.Sd          = sd_q;

endmodule

// File: tb/tb_rega_controlador.sv
// Scoreboard bench for rega_controlador (DEB_CYCLES=4, SD_PERIOD=4, FILL_TIMEOUT=20).
// Stimulus pushes expected output vectors tagged with a cycle number; a monitor
// on the falling edge pops and compares them, and checks the flag one-hot rule.
// Expected-vector bits: {Crit,Baixo,Medio,Alto,ERRO,Bs,Vs,Valvula_Ent,Sd}.
module tb_rega_controlador;

    localparam logic [8:0] C    = 9'h100;
    localparam logic [8:0] B    = 9'h080;
    localparam logic [8:0] M    = 9'h040;
    localparam logic [8:0] A    = 9'h020;
    localparam logic [8:0] E    = 9'h010;
    localparam logic [8:0] BS   = 9'h008;
    localparam logic [8:0] VS   = 9'h004;
    localparam logic [8:0] VL   = 9'h002;
    localparam logic [8:0] SDB  = 9'h001;
    localparam logic [8:0] ALL  = 9'h1FF;
    localparam logic [8:0] NOSD = 9'h1FE;

    typedef struct {
        int         cyc;
        logic [8:0] exp;
        logic [8:0] msk;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   rel_cyc;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;
    logic [8:0] act;

    rega_controlador_if bus_if ();

    rega_controlador #(
        .DEB_CYCLES   (4),
        .SD_PERIOD    (4),
        .FILL_TIMEOUT (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign act = {bus_if.Nv_Critico, bus_if.Nv_Baixo, bus_if.Nv_Medio, bus_if.Nv_Alto,
                  bus_if.ERRO, bus_if.Bs, bus_if.Vs, bus_if.Valvula_Ent, bus_if.Sd};

    task automatic applyStimulus(input logic b, input logic m, input logic a,
                                 input logic seco, input logic modo);
        bus_if.Sn_Baixo = b;
        bus_if.Sn_Medio = m;
        bus_if.Sn_Alto  = a;
        bus_if.Seco     = seco;
        bus_if.Modo_Asp = modo;
    endtask

    task automatic expectAt(input int c, input logic [8:0] e, input logic [8:0] m,
                            input string nm);
        exp_t item;
        int   pos;
        item.cyc  = c;
        item.exp  = e;
        item.msk  = m;
        item.name = nm;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, item);
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(output int r);
        rst     = 1'b1;
        rel_cyc = 1 << 30;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        r       = cyc;
        rel_cyc = cyc;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if ((act & e.msk) !== (e.exp & e.msk)) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %b required %b (mask %b)",
                     e.name, cyc, act & e.msk, e.exp & e.msk, e.msk);
        end
    endtask

    // Monitor: one-hot flag rule every cycle, plus any scoreboard entries due now
    always @(negedge clk) begin
        if (!rst && cyc > rel_cyc) begin
            checks++;
            if ($countones(act[8:4]) != 1) begin
                errors++;
                $display("[TB] FAIL onehot cycle %0d: got flags %b required exactly one set",
                         cyc, act[8:4]);
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: expectation for cycle %0d missed at cycle %0d",
                         cur.name, cur.cyc, cyc);
            end else begin
                checkOutput(cur);
            end
        end
    end

    initial begin
        int r, t;
        rst           = 1'b1;
        rel_cyc       = 1 << 30;
        bus_if.Rearme = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);

        // Reset, empty tank: critical at edge 1, filling at edge 2, Sd period 4
        doReset(r);
        expectAt(r,     9'h000,  ALL,  "reset_state");
        expectAt(r + 1, C,       NOSD, "crit_edge1");
        expectAt(r + 2, C | VL,  NOSD, "enche_edge2");
        expectAt(r + 3, 9'h000,  SDB,  "sd_low_r3");
        expectAt(r + 4, SDB,     SDB,  "sd_high_r4");
        expectAt(r + 7, SDB,     SDB,  "sd_high_r7");
        expectAt(r + 8, 9'h000,  SDB,  "sd_low_r8");

        // Fill sequence Baixo -> Medio -> Alto
        waitUntil(r + 6);
        t = cyc;
        applyStimulus(1, 0, 0, 0, 0);
        expectAt(t + 4, C | VL, NOSD, "baixo_not_yet");
        expectAt(t + 5, B | VL, NOSD, "baixo_flag");
        waitUntil(t + 8);
        t = cyc;
        applyStimulus(1, 1, 0, 0, 0);
        expectAt(t + 4, B | VL, NOSD, "medio_not_yet");
        expectAt(t + 5, M | VL, NOSD, "medio_flag");
        waitUntil(t + 8);
        t = cyc;
        applyStimulus(1, 1, 1, 0, 0);
        expectAt(t + 5, A | VL, NOSD, "alto_flag");
        expectAt(t + 6, A,      NOSD, "valve_closed");

        // Drop to Baixo, then a 3-cycle glitch on Medio must be filtered
        waitUntil(t + 8);
        t = cyc;
        applyStimulus(1, 0, 0, 0, 0);
        expectAt(t + 4, A, NOSD, "drop_not_yet");
        expectAt(t + 5, B, NOSD, "drop_to_baixo");
        waitUntil(t + 8);
        t = cyc;
        applyStimulus(1, 1, 0, 0, 0);
        waitUntil(t + 3);
        applyStimulus(1, 0, 0, 0, 0);
        expectAt(t + 5, B, NOSD, "glitch_filtered_a");
        expectAt(t + 9, B, NOSD, "glitch_filtered_b");

        // Sprinkler irrigation, mode latched on entry, stop on dry=0
        waitUntil(t + 12);
        t = cyc;
        applyStimulus(1, 1, 0, 1, 1);
        expectAt(t + 5, M,      NOSD, "rega_not_yet");
        expectAt(t + 6, M | BS, NOSD, "rega_sprinkler");
        waitUntil(t + 8);
        applyStimulus(1, 1, 0, 1, 0);
        expectAt(t + 10, M | BS, NOSD, "mode_latched");
        waitUntil(t + 12);
        t = cyc;
        applyStimulus(1, 1, 0, 0, 0);
        expectAt(t + 5, M | BS, NOSD, "seco_off_not_yet");
        expectAt(t + 6, M,      NOSD, "rega_stopped");

        // Drip irrigation, then critical level preempts irrigation
        waitUntil(t + 8);
        t = cyc;
        applyStimulus(1, 1, 0, 1, 0);
        expectAt(t + 5, M,      NOSD, "drip_not_yet");
        expectAt(t + 6, M | VS, NOSD, "rega_drip");
        waitUntil(t + 8);
        t = cyc;
        applyStimulus(0, 0, 0, 1, 0);
        expectAt(t + 5, C | VS, NOSD, "crit_during_rega");
        expectAt(t + 6, C | VL, NOSD, "crit_preempts");
        waitUntil(t + 8);
        t = cyc;
        applyStimulus(1, 1, 1, 1, 0);
        expectAt(t + 5, A | VL, NOSD, "refill_alto");
        expectAt(t + 6, A,      NOSD, "refill_done");
        expectAt(t + 7, A | VS, NOSD, "resume_drip");
        waitUntil(t + 8);
        t = cyc;
        applyStimulus(1, 1, 1, 0, 0);
        expectAt(t + 5, A | VS, NOSD, "drip_not_off_yet");
        expectAt(t + 6, A,      NOSD, "drip_off");

        // Invalid level 101: error, Rearme ignored until level valid again
        waitUntil(t + 10);
        t = cyc;
        applyStimulus(1, 0, 1, 0, 0);
        expectAt(t + 4, A, NOSD, "invalid_not_yet");
        expectAt(t + 5, E, ALL,  "invalid_erro");
        expectAt(t + 6, E, ALL,  "falha_state");
        waitUntil(t + 8);
        bus_if.Rearme = 1'b1;
        waitUntil(t + 9);
        bus_if.Rearme = 1'b0;
        expectAt(t + 10, E, ALL, "rearme_ignored");
        waitUntil(t + 12);
        t = cyc;
        applyStimulus(1, 1, 1, 0, 0);
        expectAt(t + 7, E, ALL, "valid_still_falha");
        waitUntil(t + 8);
        t = cyc;
        bus_if.Rearme = 1'b1;
        expectAt(t,     E,      ALL, "before_rearme");
        expectAt(t + 1, A,      ALL, "rearme_recovers");
        expectAt(t + 3, 9'h000, SDB, "sd_low_after_err");
        expectAt(t + 4, SDB,    SDB, "sd_toggle_after_err");
        waitUntil(t + 1);
        bus_if.Rearme = 1'b0;

        // Fresh reset with empty tank: watchdog (if built in) trips after 20 cycles of ENCHE
        waitUntil(t + 8);
        applyStimulus(0, 0, 0, 0, 0);
        doReset(r);
        expectAt(r,     9'h000, ALL,  "reset2_state");
        expectAt(r + 2, C | VL, NOSD, "enche_again");
`ifdef REGA_WATCHDOG_EN
        expectAt(r + 21, C | VL, NOSD, "watchdog_not_yet");
        expectAt(r + 22, E,      ALL,  "watchdog_trip");
`else
        expectAt(r + 22, C | VL, NOSD, "enche_waits_a");
        expectAt(r + 30, C | VL, NOSD, "enche_waits_b");
`endif
        waitUntil(r + 35);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
